if_stage: RTL and testbench

Instruction-fetch stage of the 5-stage RV32I pipeline. It sits directly upstream of the decode stage. It owns the program counter and issues in-order word fetches to instruction memory over a req/gnt/rvalid handshake, with at most two fetches outstanding. It buffers returned words in a 2-entry queue and presents one {instruction, PC} pair per cycle to decode, honouring stalls and branch/jump redirects.

---
 rtl/if_stage.sv | 174 +++++++++++++++++
 tb/tb_if_stage.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/if_stage.sv
// RV32I instruction-fetch stage: owns the PC, keeps up to two word fetches in flight and
// presents one {instruction, PC} pair per cycle to decode. Optional build macro: IF_MISALIGN_CHECK_EN.
module if_stage #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        stall_i,
   input  logic        ID_branch_en_i,
   input  logic [31:0] ID_branch_addr_i,
   output logic        imem_req_o,
   output logic [31:0] imem_addr_o,
   input  logic        imem_gnt_i,
   input  logic        imem_rvalid_i,
   input  logic [31:0] imem_rdata_i,
   output logic [31:0] IF_Instruction_o,
   output logic [31:0] IF_PC_o,
   output logic        IF_valid_o,
   output logic        IF_misalign_o
);

   logic [31:0] pc_q, pc_d;
   logic [1:0]  out_cnt_q, out_cnt_d;
   logic [1:0]  drop_cnt_q, drop_cnt_d;
   logic [1:0]  fifo_cnt_q, fifo_cnt_d;
   logic [31:0] fifo_instr_q [2];
   logic [31:0] fifo_pc_q [2];
   logic [31:0] pend_pc_q [2];
   logic        fifo_wp_q, fifo_rp_q, fifo_wp_d, fifo_rp_d;
   logic        pend_wp_q, pend_rp_q;
   logic [31:0] instr_q, instr_d;
   logic [31:0] out_pc_q, out_pc_d;
   logic        valid_q, valid_d;

   logic [31:0] branch_addr;
   logic        halt;
   logic        credit_ok;
   logic        grant;
   logic        resp;
   logic        resp_keep;
   logic [31:0] resp_pc;
   logic        fifo_pop;
   logic        fifo_push;
   logic        bypass;

`ifdef IF_MISALIGN_CHECK_EN
   logic misalign_q, misalign_d;

   assign branch_addr   = ID_branch_addr_i;
   assign halt          = misalign_q;
   assign misalign_d    = ID_branch_en_i ? (ID_branch_addr_i[1:0] != 2'b00) : misalign_q;
   assign IF_misalign_o = misalign_q;

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) misalign_q <= 1'b0;
      else        misalign_q <= misalign_d;
   end
`else
   logic unused_addr_lsb;

   assign unused_addr_lsb = ^ID_branch_addr_i[1:0];
   assign branch_addr     = {ID_branch_addr_i[31:2], 2'b00};
   assign halt            = 1'b0;
   assign IF_misalign_o   = 1'b0;
`endif

   // Gating with rst_i keeps req low in reset and lets it rise as soon as reset releases.
   assign credit_ok   = ({1'b0, out_cnt_q} + {1'b0, fifo_cnt_q}) < 3'd2;
   assign imem_req_o  = rst_i & credit_ok & ~ID_branch_en_i & ~halt;
   assign imem_addr_o = pc_q;
   assign grant       = imem_req_o & imem_gnt_i;

   // A response with nothing outstanding is a protocol error and is ignored.
   assign resp      = imem_rvalid_i & (out_cnt_q != 2'd0);
   assign resp_pc   = pend_pc_q[pend_rp_q];
   assign resp_keep = resp & (drop_cnt_q == 2'd0) & ~ID_branch_en_i;
   assign fifo_pop  = ~ID_branch_en_i & ~stall_i & (fifo_cnt_q != 2'd0);
   assign bypass    = ~ID_branch_en_i & ~stall_i & (fifo_cnt_q == 2'd0) & resp_keep;
   assign fifo_push = resp_keep & ~bypass;

   always_comb begin
      pc_d       = pc_q;
      out_cnt_d  = out_cnt_q + {1'b0, grant} - {1'b0, resp};
      drop_cnt_d = drop_cnt_q;
      fifo_cnt_d = fifo_cnt_q + {1'b0, fifo_push} - {1'b0, fifo_pop};
      fifo_wp_d  = fifo_wp_q ^ fifo_push;
      fifo_rp_d  = fifo_rp_q ^ fifo_pop;
      instr_d    = instr_q;
      out_pc_d   = out_pc_q;
      valid_d    = valid_q;

      if (grant) pc_d = pc_q + 32'd4;
      if (resp && drop_cnt_q != 2'd0) drop_cnt_d = drop_cnt_q - 2'd1;

      // Everything still outstanding after this edge belongs to the abandoned path.
      if (ID_branch_en_i) begin
         pc_d       = branch_addr;
         drop_cnt_d = out_cnt_d;
         fifo_cnt_d = 2'd0;
         fifo_wp_d  = 1'b0;
         fifo_rp_d  = 1'b0;
      end

      if (ID_branch_en_i) begin
         instr_d = NOP_INSTR;
         valid_d = 1'b0;
      end else if (stall_i) begin
         instr_d = instr_q;
      end else if (fifo_cnt_q != 2'd0) begin
         instr_d  = fifo_instr_q[fifo_rp_q];
         out_pc_d = fifo_pc_q[fifo_rp_q];
         valid_d  = 1'b1;
      end else if (resp_keep) begin
         instr_d  = imem_rdata_i;
         out_pc_d = resp_pc;
         valid_d  = 1'b1;
      end else begin
         instr_d = NOP_INSTR;
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         pc_q       <= RESET_PC;
         out_cnt_q  <= 2'd0;
         drop_cnt_q <= 2'd0;
         fifo_cnt_q <= 2'd0;
         fifo_wp_q  <= 1'b0;
         fifo_rp_q  <= 1'b0;
         pend_wp_q  <= 1'b0;
         pend_rp_q  <= 1'b0;
         instr_q    <= NOP_INSTR;
         out_pc_q   <= 32'd0;
         valid_q    <= 1'b0;
         for (int i = 0; i < 2; i++) begin
            fifo_instr_q[i] <= NOP_INSTR;
            fifo_pc_q[i]    <= 32'd0;
            pend_pc_q[i]    <= 32'd0;
         end
      end else begin
         pc_q       <= pc_d;
         out_cnt_q  <= out_cnt_d;
         drop_cnt_q <= drop_cnt_d;
         fifo_cnt_q <= fifo_cnt_d;
         fifo_wp_q  <= fifo_wp_d;
         fifo_rp_q  <= fifo_rp_d;
         instr_q    <= instr_d;
         out_pc_q   <= out_pc_d;
         valid_q    <= valid_d;
         if (grant) begin
            pend_pc_q[pend_wp_q] <= pc_q;
            pend_wp_q            <= ~pend_wp_q;
         end
         if (resp) pend_rp_q <= ~pend_rp_q;
         if (fifo_push) begin
            fifo_instr_q[fifo_wp_q] <= imem_rdata_i;
            fifo_pc_q[fifo_wp_q]    <= resp_pc;
         end
      end
   end

   assign IF_Instruction_o = instr_q;
   assign IF_PC_o          = out_pc_q;
   assign IF_valid_o       = valid_q;

`ifndef SYNTHESIS
   always_ff @(posedge clk_i) begin
      if (rst_i) assert (!(imem_rvalid_i && out_cnt_q == 2'd0));
   end
`endif

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: stream, stall, redirect with drops, grant wait,
// PC wrap (second instance), misaligned redirect and mid-run reset.
module tb_if_stage;

   localparam logic [31:0] NOP  = 32'h0000_0013;
   localparam logic [31:0] XMSK = 32'hA5A5_0000;

   logic        clk_i = 1'b0;
   logic        rst_n = 1'b0;
   logic        stall = 1'b0;
   logic        br_en = 1'b0;
   logic [31:0] br_addr = 32'd0;
   logic        gnt = 1'b1;
   logic        rsp_hold = 1'b0;

   logic        req, valid, misalign, rvalid;
   logic [31:0] addr, instr, pc, rdata;

   logic        req2, valid2, misalign2, rvalid2;
   logic [31:0] addr2, instr2, pc2, rdata2;

   int checks = 0;
   int errors = 0;

   always #5 clk_i = ~clk_i;

   if_stage dut (
      .clk_i(clk_i), .rst_i(rst_n), .stall_i(stall),
      .ID_branch_en_i(br_en), .ID_branch_addr_i(br_addr),
      .imem_req_o(req), .imem_addr_o(addr), .imem_gnt_i(gnt),
      .imem_rvalid_i(rvalid), .imem_rdata_i(rdata),
      .IF_Instruction_o(instr), .IF_PC_o(pc), .IF_valid_o(valid),
      .IF_misalign_o(misalign)
   );

   if_stage #(.RESET_PC(32'hFFFF_FFF8)) dut2 (
      .clk_i(clk_i), .rst_i(rst_n), .stall_i(1'b0),
      .ID_branch_en_i(1'b0), .ID_branch_addr_i(32'd0),
      .imem_req_o(req2), .imem_addr_o(addr2), .imem_gnt_i(1'b1),
      .imem_rvalid_i(rvalid2), .imem_rdata_i(rdata2),
      .IF_Instruction_o(instr2), .IF_PC_o(pc2), .IF_valid_o(valid2),
      .IF_misalign_o(misalign2)
   );

   // In-order memory: responses come at least one cycle after grant, can be held back.
   logic [31:0] mq [4];
   logic [2:0]  mq_n;
   logic [2:0]  widx;
   assign rvalid = (mq_n != 3'd0) && !rsp_hold;
   assign rdata  = mq[0] ^ XMSK;
   assign widx   = mq_n - {2'b00, rvalid};

   always @(posedge clk_i or negedge rst_n) begin
      if (!rst_n) begin
         mq_n <= 3'd0;
      end else begin
         if (rvalid) begin
            mq[0] <= mq[1];
            mq[1] <= mq[2];
            mq[2] <= mq[3];
         end
         if (req && gnt) mq[widx[1:0]] <= addr;
         mq_n <= mq_n + {2'b00, req && gnt} - {2'b00, rvalid};
      end
   end

   always @(posedge clk_i or negedge rst_n) begin
      if (!rst_n) begin
         rvalid2 <= 1'b0;
         rdata2  <= 32'd0;
      end else begin
         rvalid2 <= req2;
         rdata2  <= addr2 ^ XMSK;
      end
   end

   task automatic step();
      @(negedge clk_i);
   endtask

   task automatic test_reset();
      step();
      step();
      checks++;
      if (req !== 1'b0 || instr !== NOP || pc !== 32'd0 || valid !== 1'b0 || misalign !== 1'b0) begin
         errors++;
         $display("FAIL reset_outputs req=%b instr=%h pc=%h valid=%b mis=%b, want 0/%h/0/0/0",
                  req, instr, pc, valid, misalign, NOP);
      end
      checks++;
      if (req2 !== 1'b0) begin
         errors++;
         $display("FAIL reset_req2 got %b want 0", req2);
      end
      rst_n = 1'b1;
      #1;
      checks++;
      if (req !== 1'b1 || addr !== 32'd0) begin
         errors++;
         $display("FAIL first_req req=%b addr=%h want 1/00000000", req, addr);
      end
      checks++;
      if (addr2 !== 32'hFFFF_FFF8) begin
         errors++;
         $display("FAIL wrap_addr0 got %h want fffffff8", addr2);
      end
   endtask

   task automatic test_stream();
      logic [31:0] e;
      step();
      checks++;
      if (valid !== 1'b0) begin
         errors++;
         $display("FAIL stream_cycle2_valid got %b want 0", valid);
      end
      checks++;
      if (addr2 !== 32'hFFFF_FFFC) begin
         errors++;
         $display("FAIL wrap_addr1 got %h want fffffffc", addr2);
      end
      for (int i = 0; i < 6; i++) begin
         step();
         e = 32'(i * 4);
         checks++;
         if (valid !== 1'b1 || pc !== e || instr !== (e ^ XMSK)) begin
            errors++;
            $display("FAIL stream_%0d valid=%b pc=%h instr=%h want 1/%h/%h", i, valid, pc, instr, e, e ^ XMSK);
         end
         if (i == 0) begin
            checks++;
            if (addr2 !== 32'h0000_0000 || pc2 !== 32'hFFFF_FFF8) begin
               errors++;
               $display("FAIL wrap_addr2 addr=%h pc=%h want 00000000/fffffff8", addr2, pc2);
            end
         end
      end
   endtask

   task automatic test_stall();
      logic [31:0] e;
      stall = 1'b1;
      for (int i = 1; i <= 3; i++) begin
         step();
         #1;
         checks++;
         if (valid !== 1'b1 || pc !== 32'd20 || instr !== (32'd20 ^ XMSK)) begin
            errors++;
            $display("FAIL stall_hold_%0d valid=%b pc=%h want 1/00000014", i, valid, pc);
         end
         if (i < 3) begin
            checks++;
            if (req !== 1'b0) begin
               errors++;
               $display("FAIL stall_credit_%0d req=%b want 0", i, req);
            end
         end
      end
      stall = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         e = 32'(24 + i * 4);
         checks++;
         if (valid !== 1'b1 || pc !== e || instr !== (e ^ XMSK)) begin
            errors++;
            $display("FAIL stall_resume_%0d valid=%b pc=%h instr=%h want 1/%h", i, valid, pc, instr, e);
         end
      end
   endtask

   task automatic test_redirect();
      rsp_hold = 1'b1;
      step();
      checks++;
      if (valid !== 1'b0 || instr !== NOP || pc !== 32'd32) begin
         errors++;
         $display("FAIL redir_bubble valid=%b instr=%h pc=%h want 0/%h/00000020", valid, instr, pc, NOP);
      end
      br_en   = 1'b1;
      br_addr = 32'h0000_0100;
      #1;
      checks++;
      if (req !== 1'b0) begin
         errors++;
         $display("FAIL redir_full_req got %b want 0", req);
      end
      step();
      br_en    = 1'b0;
      rsp_hold = 1'b0;
      for (int i = 0; i < 3; i++) begin
         #1;
         checks++;
         if (valid !== 1'b0 || instr !== NOP) begin
            errors++;
            $display("FAIL redir_drop_%0d valid=%b instr=%h want 0/%h", i, valid, instr, NOP);
         end
         if (i == 1) begin
            checks++;
            if (req !== 1'b1 || addr !== 32'h0000_0100) begin
               errors++;
               $display("FAIL redir_target_req req=%b addr=%h want 1/00000100", req, addr);
            end
         end
         step();
      end
      checks++;
      if (valid !== 1'b1 || pc !== 32'h100 || instr !== (32'h100 ^ XMSK)) begin
         errors++;
         $display("FAIL redir_first valid=%b pc=%h instr=%h want 1/00000100", valid, pc, instr);
      end
      step();
      checks++;
      if (valid !== 1'b1 || pc !== 32'h104) begin
         errors++;
         $display("FAIL redir_second valid=%b pc=%h want 1/00000104", valid, pc);
      end
   endtask

   task automatic test_gnt_wait();
      gnt = 1'b0;
      for (int i = 0; i < 4; i++) begin
         #1;
         checks++;
         if (req !== 1'b1 || addr !== 32'h10C) begin
            errors++;
            $display("FAIL gnt_wait_%0d req=%b addr=%h want 1/0000010c", i, req, addr);
         end
         if (i == 1) begin
            checks++;
            if (valid !== 1'b1 || pc !== 32'h108) begin
               errors++;
               $display("FAIL gnt_wait_out valid=%b pc=%h want 1/00000108", valid, pc);
            end
         end
         if (i < 3) step();
      end
      br_en   = 1'b1;
      br_addr = 32'h0000_0300;
      #1;
      checks++;
      if (req !== 1'b0) begin
         errors++;
         $display("FAIL gnt_wait_redir_req got %b want 0", req);
      end
      step();
      br_en = 1'b0;
      gnt   = 1'b1;
      #1;
      checks++;
      if (req !== 1'b1 || addr !== 32'h300) begin
         errors++;
         $display("FAIL gnt_wait_target req=%b addr=%h want 1/00000300", req, addr);
      end
      step();
      step();
      checks++;
      if (valid !== 1'b1 || pc !== 32'h300 || instr !== (32'h300 ^ XMSK)) begin
         errors++;
         $display("FAIL gnt_wait_first valid=%b pc=%h want 1/00000300", valid, pc);
      end
   endtask

   task automatic test_misalign();
      br_en   = 1'b1;
      br_addr = 32'h0000_0102;
      step();
      br_en = 1'b0;
      #1;
`ifdef IF_MISALIGN_CHECK_EN
      for (int i = 0; i < 2; i++) begin
         checks++;
         if (misalign !== 1'b1 || req !== 1'b0 || valid !== 1'b0) begin
            errors++;
            $display("FAIL misalign_halt_%0d mis=%b req=%b valid=%b want 1/0/0", i, misalign, req, valid);
         end
         step();
      end
      br_en   = 1'b1;
      br_addr = 32'h0000_0200;
      step();
      br_en = 1'b0;
      #1;
      checks++;
      if (misalign !== 1'b0 || req !== 1'b1 || addr !== 32'h200) begin
         errors++;
         $display("FAIL misalign_clear mis=%b req=%b addr=%h want 0/1/00000200", misalign, req, addr);
      end
      step();
      step();
      checks++;
      if (valid !== 1'b1 || pc !== 32'h200) begin
         errors++;
         $display("FAIL misalign_resume valid=%b pc=%h want 1/00000200", valid, pc);
      end
`else
      checks++;
      if (misalign !== 1'b0 || req !== 1'b1 || addr !== 32'h100) begin
         errors++;
         $display("FAIL align_force mis=%b req=%b addr=%h want 0/1/00000100", misalign, req, addr);
      end
      step();
      step();
      checks++;
      if (valid !== 1'b1 || pc !== 32'h100) begin
         errors++;
         $display("FAIL align_resume valid=%b pc=%h want 1/00000100", valid, pc);
      end
`endif
   endtask

   task automatic test_reset_mid();
      step();
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if (req !== 1'b0 || valid !== 1'b0 || pc !== 32'd0 || instr !== NOP) begin
         errors++;
         $display("FAIL mid_reset req=%b valid=%b pc=%h instr=%h want 0/0/0/%h", req, valid, pc, instr, NOP);
      end
      step();
      rst_n = 1'b1;
      #1;
      checks++;
      if (req !== 1'b1 || addr !== 32'd0) begin
         errors++;
         $display("FAIL mid_reset_restart req=%b addr=%h want 1/00000000", req, addr);
      end
      step();
      step();
      checks++;
      if (valid !== 1'b1 || pc !== 32'd0) begin
         errors++;
         $display("FAIL mid_reset_first valid=%b pc=%h want 1/00000000", valid, pc);
      end
   endtask

   initial begin
      test_reset();
      test_stream();
      test_stall();
      test_redirect();
      test_gnt_wait();
      test_misalign();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
